// File: rtl/emmc_req_arb.sv
// emmc_req_arb: round-robin front end for the eMMC block-transfer engine.
// It grants one requester at a time and runs exactly one block per grant.
// For each grant it pulses the engine start, steers write bytes and read
// strobes, counts the block's bytes and watches for a hung engine.
module emmc_req_arb #(
    parameter int NUM_REQ        = 2,
    parameter int BLK_BYTES      = 512,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   req_we_i,
    input  logic [NUM_REQ*8-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   wr_take_o,
    output logic [7:0]           rd_dat_o,
    output logic [NUM_REQ-1:0]   rd_valid_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic                 fault_o,
    output logic                 busy_o,
    output logic                 sm_we_o,
    output logic                 sm_start_o,
    output logic [7:0]           sm_dat_o,
    input  logic [7:0]           sm_dat_i,
    input  logic                 sm_dvalid_i,
    input  logic                 sm_ready_i
);

    // Index widths. The doubled request vector used by the round-robin
    // search needs one extra index bit.
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDXP_W = IDX_W + 1;
    localparam int CNT_W  = $clog2(BLK_BYTES + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLK_BYTES - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDXP_W-1:0] NREQ_P    = IDXP_W'(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_XFER,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   winner_reg, winner_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [WD_W-1:0]    wdog_reg, wdog_next;
    logic               we_reg, we_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic                 granted;
    logic                 fwd_strobe;
    logic                 last_strobe;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDXP_W-1:0]    cand;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   sel;

    // A grant is live from LAUNCH through DRAIN; FAULT drops it for good.
    assign granted = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT_BUSY) ||
                     (state_reg == ST_XFER)   || (state_reg == ST_DRAIN);

    // Strobes seen before the engine reports busy still belong to this block,
    // so they are forwarded and counted the same way as in XFER.
    assign fwd_strobe  = sm_dvalid_i &&
                         ((state_reg == ST_WAIT_BUSY) || (state_reg == ST_XFER));
    assign last_strobe = fwd_strobe && (byte_cnt_reg == LAST_BYTE);

    assign req_dbl = {req_i, req_i};

    // Round-robin pick: the first request above the last winner, with wrap.
    // The loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_reg} + IDXP_W'(i);
            if (req_dbl[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = (cand >= NREQ_P) ? IDX_W'(cand - NREQ_P) : IDX_W'(cand);
            end
        end
    end

    // Next-state logic, byte counting and the hung-transfer watchdog.
    always_comb begin
        state_next    = state_reg;
        winner_next   = winner_reg;
        last_next     = last_reg;
        byte_cnt_next = byte_cnt_reg;
        wdog_next     = wdog_reg;
        we_next       = we_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A completion pulse blocks arbitration for one cycle, so the
                // requester can drop its request before it could be re-granted.
                if (sm_ready_i && pick_valid && !done_reg) begin
                    winner_next   = pick_idx;
                    we_next       = req_we_i[pick_idx];
                    byte_cnt_next = '0;
                    state_next    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (fwd_strobe) begin
                    byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                end
                if (last_strobe) begin
                    state_next = ST_DRAIN;
                end else if (!sm_ready_i) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (fwd_strobe) begin
                    byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                end
                if (last_strobe) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sm_ready_i) begin
                    done_next  = 1'b1;
                    last_next  = winner_reg;
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The watchdog counts idle cycles of a live grant. A strobe or any
        // state change restarts it. A strobe on the expiring cycle therefore
        // keeps the transfer alive.
        if (granted) begin
            if (sm_dvalid_i || (state_next != state_reg)) begin
                wdog_next = '0;
            end else if (wdog_reg == WD_LIMIT) begin
                wdog_next  = '0;
                err_next   = 1'b1;
                state_next = ST_FAULT;
            end else begin
                wdog_next = wdog_reg + WD_W'(1);
            end
        end else begin
            wdog_next = '0;
        end
    end

    // State and context registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg    <= ST_IDLE;
            winner_reg   <= '0;
            last_reg     <= IDX_W'(NUM_REQ - 1);
            byte_cnt_reg <= '0;
            wdog_reg     <= '0;
            we_reg       <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            winner_reg   <= winner_next;
            last_reg     <= last_next;
            byte_cnt_reg <= byte_cnt_next;
            wdog_reg     <= wdog_next;
            we_reg       <= we_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Per-requester decode of grant, byte handshakes and completion pulses.
    // The winner index stays valid in IDLE, so done/err can decode from it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign sel[gi]        = (winner_reg == IDX_W'(gi));
            assign gnt_o[gi]      = granted && sel[gi];
            assign wr_take_o[gi]  = fwd_strobe && we_reg && sel[gi];
            assign rd_valid_o[gi] = fwd_strobe && !we_reg && sel[gi];
            assign done_o[gi]     = done_reg && sel[gi];
            assign err_o[gi]      = err_reg && sel[gi];
        end
    endgenerate

    // Write-byte steering from the granted requester; 0 while nobody holds a grant.
    always_comb begin
        sm_dat_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted && (winner_reg == IDX_W'(i))) begin
                sm_dat_o = req_dat_i[i*8 +: 8];
            end
        end
    end

    assign rd_dat_o   = sm_dat_i;
    assign sm_we_o    = we_reg;
    assign sm_start_o = (state_reg == ST_LAUNCH);
    assign busy_o     = granted;
    assign fault_o    = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_emmc_req_arb.sv
// Directed-plus-random bench for emmc_req_arb with a behavioural engine model.
// Expected grant order comes from a round-robin model. Expected write bytes
// come from per-requester byte sources. Expected read bytes are the engine's
// counting pattern.
module tb_emmc_req_arb;

    localparam int NREQ = 3;
    localparam int BLK  = 512;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              arst;
    logic [NREQ-1:0]   req, req_we;
    logic [NREQ*8-1:0] req_dat;
    logic [NREQ-1:0]   gnt, wr_take, rd_valid, done, err;
    logic [7:0]        rd_dat, sm_dat_o, sm_dat_i;
    logic              fault, busy, sm_we, sm_start, sm_dvalid, sm_ready;

    int checks = 0;
    int errors = 0;
    int last_w = NREQ - 1;
    logic [7:0] wsrc [NREQ];

    always #5 clk = ~clk;

    emmc_req_arb #(
        .NUM_REQ(NREQ),
        .BLK_BYTES(BLK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .arst_i(arst),
        .req_i(req),
        .req_we_i(req_we),
        .req_dat_i(req_dat),
        .gnt_o(gnt),
        .wr_take_o(wr_take),
        .rd_dat_o(rd_dat),
        .rd_valid_o(rd_valid),
        .done_o(done),
        .err_o(err),
        .fault_o(fault),
        .busy_o(busy),
        .sm_we_o(sm_we),
        .sm_start_o(sm_start),
        .sm_dat_o(sm_dat_o),
        .sm_dat_i(sm_dat_i),
        .sm_dvalid_i(sm_dvalid),
        .sm_ready_i(sm_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester above the previous winner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (last_w + i) % NREQ;
            if (((32'(r) >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic drive_wdat();
        for (int r = 0; r < NREQ; r++) req_dat[r*8 +: 8] = wsrc[r];
    endtask

    // Requesters step to their next byte whenever their byte was taken.
    task automatic advance_wsrc();
        for (int r = 0; r < NREQ; r++)
            if (((32'(wr_take) >> r) & 1) != 0) wsrc[r] = wsrc[r] + 8'd1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_wrtake"}, 32'(wr_take), 0);
        chk({tag, "_rdvalid"}, 32'(rd_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_smwe"}, 32'(sm_we), 0);
        chk({tag, "_start"}, 32'(sm_start), 0);
        chk({tag, "_smdat"}, 32'(sm_dat_o), 0);
    endtask

    // One grant. mode 0 runs a full block, mode 1 hangs the engine after 100
    // bytes, and mode 2 resets mid-transfer after 300 bytes.
    task automatic run_xfer(input logic [NREQ-1:0] r, input logic [NREQ-1:0] we,
                            input int ready_hold, input bit ready_with_last,
                            input bit drain_strobe, input int mode);
        int w, k, limit, nd, n_wt, n_rv;
        bit dv, is_wr;
        logic [7:0] wbase, exp_b;
        logic [NREQ-1:0] gmask;

        for (int i = 0; i < ready_hold; i++) begin
            @(negedge clk);
            req = r; req_we = we; sm_ready = 1'b0; sm_dvalid = 1'b0; drive_wdat();
            #1;
            chk("gate_gnt", 32'(gnt), 0);
            chk("gate_start", 32'(sm_start), 0);
        end
        @(negedge clk);
        req = r; req_we = we; sm_ready = 1'b1; sm_dvalid = 1'b0; drive_wdat();
        #1;
        chk("arb_gnt", 32'(gnt), 0);
        chk("arb_busy", 32'(busy), 0);
        w     = rr_pick(r);
        is_wr = ((32'(we) >> w) & 1) != 0;
        wbase = wsrc[w];
        gmask = NREQ'(1 << w);

        @(negedge clk); drive_wdat(); #1;
        chk("launch_gnt", 32'(gnt), 32'(gmask));
        chk("launch_start", 32'(sm_start), 1);
        chk("launch_we", 32'(sm_we), 32'(is_wr));
        chk("launch_busy", 32'(busy), 1);

        @(negedge clk); drive_wdat(); #1;
        chk("wait_start", 32'(sm_start), 0);
        chk("wait_gnt", 32'(gnt), 32'(gmask));

        limit = (mode == 1) ? 100 : (mode == 2) ? 300 : BLK;
        k = 0; n_wt = 0; n_rv = 0;
        while (k < limit) begin
            @(negedge clk);
            dv        = ($urandom_range(0, 3) != 0);
            sm_dvalid = dv;
            sm_dat_i  = dv ? k[7:0] : 8'($urandom);
            sm_ready  = ready_with_last && dv && (k == limit - 1);
            drive_wdat();
            #1;
            chk("rd_dat", 32'(rd_dat), 32'(sm_dat_i));
            chk("wr_take", 32'(wr_take), (dv && is_wr) ? 32'(gmask) : 0);
            chk("rd_valid", 32'(rd_valid), (dv && !is_wr) ? 32'(gmask) : 0);
            chk("xfer_gnt", 32'(gnt), 32'(gmask));
            if (dv && is_wr) begin
                exp_b = wbase + k[7:0];
                chk("sm_dat", 32'(sm_dat_o), 32'(exp_b));
                chk("sm_we", 32'(sm_we), 1);
            end
            if ((wr_take & gmask) != 0) n_wt++;
            if ((rd_valid & gmask) != 0) n_rv++;
            advance_wsrc();
            if (dv) k++;
        end

        if (mode == 0) begin
            nd = ready_with_last ? 0 : $urandom_range(1, 4);
            for (int i = 0; i < nd; i++) begin
                @(negedge clk);
                sm_ready = 1'b0; sm_dvalid = drain_strobe && (i == 0); sm_dat_i = 8'hA5;
                #1;
                chk("drain_wrtake", 32'(wr_take), 0);
                chk("drain_rdvalid", 32'(rd_valid), 0);
                chk("drain_done", 32'(done), 0);
                chk("drain_gnt", 32'(gnt), 32'(gmask));
            end
            @(negedge clk); sm_ready = 1'b1; sm_dvalid = 1'b0; #1;
            chk("drainrdy_done", 32'(done), 0);
            chk("drainrdy_gnt", 32'(gnt), 32'(gmask));
            @(negedge clk); #1;
            chk("done", 32'(done), 32'(gmask));
            chk("done_gnt", 32'(gnt), 0);
            chk("done_busy", 32'(busy), 0);
            chk("n_wr_take", n_wt, is_wr ? BLK : 0);
            chk("n_rd_valid", n_rv, is_wr ? 0 : BLK);
            $display("xfer req=%b we=%b winner=%0d wr=%0d bytes_w=%0d bytes_r=%0d",
                     r, we, w, is_wr, n_wt, n_rv);
            last_w = w;
        end else if (mode == 1) begin
            for (int i = 1; i <= TMO; i++) begin
                @(negedge clk); sm_dvalid = 1'b0; #1;
                chk("hang_err", 32'(err), 0);
                chk("hang_gnt", 32'(gnt), 32'(gmask));
            end
            @(negedge clk); #1;
            chk("tmo_err", 32'(err), 32'(gmask));
            chk("tmo_fault", 32'(fault), 1);
            chk("tmo_gnt", 32'(gnt), 0);
            chk("tmo_busy", 32'(busy), 0);
            @(negedge clk); #1;
            chk("tmo_err_pulse", 32'(err), 0);
            chk("tmo_fault_hold", 32'(fault), 1);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); sm_ready = 1'b1; req = '1; #1;
                chk("fault_gnt", 32'(gnt), 0);
                chk("fault_start", 32'(sm_start), 0);
                chk("fault_sticky", 32'(fault), 1);
            end
            $display("timeout req=%b winner=%0d err observed after %0d idle cycles", r, w, TMO);
        end else begin
            @(negedge clk);
            arst = 1'b1; sm_dvalid = 1'b0; sm_ready = 1'b1; sm_dat_i = 8'h00;
            #1;
            chk_reset_outputs("midrst");
            @(negedge clk); arst = 1'b0; req = '0; req_we = '0;
            last_w = NREQ - 1;
            $display("reset mid-transfer req=%b winner=%0d after %0d bytes", r, w, limit);
        end
    endtask

    initial begin
        arst = 1'b1; req = '1; req_we = '1; req_dat = '0;
        sm_dat_i = 8'h00; sm_dvalid = 1'b1; sm_ready = 1'b1;
        for (int r = 0; r < NREQ; r++) wsrc[r] = 8'(16 * r + 3);
        #1;
        chk_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst1");
        @(negedge clk); arst = 1'b0; req = '0; req_we = '0; sm_dvalid = 1'b0;

        // Contention: 0,1,0,1 while two requests are held.
        run_xfer(3'b011, 3'b000, 0, 0, 0, 0);
        run_xfer(3'b011, 3'b010, 0, 0, 0, 0);
        run_xfer(3'b011, 3'b001, 0, 0, 0, 0);
        run_xfer(3'b011, 3'b000, 0, 0, 0, 0);
        // Single read.
        run_xfer(3'b001, 3'b000, 0, 0, 0, 0);
        // Write steering from requester 1.
        run_xfer(3'b010, 3'b010, 0, 0, 0, 0);
        // Ready gating for 20 cycles.
        run_xfer(3'b001, 3'b000, 20, 0, 0, 0);
        // Last strobe together with ready, then a stray strobe in DRAIN.
        run_xfer(3'b100, 3'b100, 0, 1, 0, 0);
        run_xfer(3'b101, 3'b001, 0, 0, 1, 0);
        // Randomised request patterns and directions.
        for (int i = 0; i < 4; i++)
            run_xfer(NREQ'($urandom_range(1, (1 << NREQ) - 1)), NREQ'($urandom), 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        // Reset after 300 bytes, then a clean full transfer.
        run_xfer(3'b010, 3'b000, 0, 0, 0, 2);
        run_xfer(3'b110, 3'b110, 0, 0, 0, 0);
        // Hung engine after 100 bytes.
        run_xfer(3'b001, 3'b000, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/emmc_req_arb.md
# emmc_req_arb

Round-robin scheduler that shares the single eMMC block-transfer engine's byte-stream user port (`we`/`start`/`dat`/`dvalid`/`ready`) between `NUM_REQ` requesters. Each grant runs exactly one `BLK_BYTES` block transfer, read or write. For each grant the scheduler:
- issues the start pulse;
- steers write bytes and read strobes;
- counts bytes;
- watches for a hung transfer.

It sits between the system-side clients and the eMMC state machine, on the same clock.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `BLK_BYTES`, 512: bytes per block; must match the engine's block size.
- `TIMEOUT_CYCLES`, 1048576: idle cycles allowed before a transfer is declared hung.

Ports:
- `clk_i`  in  1  system clock; the eMMC engine runs on the same clock.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  `NUM_REQ`  per-requester transfer request; held until `done_o` or `err_o`.
- `req_we_i`  in  `NUM_REQ`  per-requester direction: 1 = write, 0 = read.
- `req_dat_i`  in  `NUM_REQ`x8  per-requester write byte.
- `gnt_o`  out  `NUM_REQ`  one-hot grant.
- `wr_take_o`  out  `NUM_REQ`  write byte consumed this cycle; the requester advances to its next byte.
- `rd_dat_o`  out  8  read byte, broadcast to all requesters.
- `rd_valid_o`  out  `NUM_REQ`  read byte valid for the granted requester.
- `done_o`  out  `NUM_REQ`  1-cycle completion pulse.
- `err_o`  out  `NUM_REQ`  1-cycle timeout pulse.
- `fault_o`  out  1  sticky hung-engine flag.
- `busy_o`  out  1  a grant is active.
- `sm_we_o`  out  1  engine direction.
- `sm_start_o`  out  1  engine start pulse.
- `sm_dat_o`  out  8  engine write byte.
- `sm_dat_i`  in  8  engine read byte.
- `sm_dvalid_i`  in  1  engine byte strobe (write byte taken or read byte valid).
- `sm_ready_i`  in  1  engine idle and ready.

## Operation
- **States:** IDLE, LAUNCH, WAIT_BUSY, XFER, DRAIN, FAULT.
- **IDLE:**
  - Arbitration happens only when `sm_ready_i`=1, `|req_i`=1 and `done_o`/`err_o` was not asserted this cycle.
  - The winner is the first set `req_i` bit searching upward, with wrap, from `last+1`.
  - `last` resets to `NUM_REQ-1`, so requester 0 has first priority.
  - On a win: register the winner index, latch `req_we_i[winner]` into `sm_we_o`, and go to LAUNCH.
- **LAUNCH:**
  - `gnt_o[winner]`=1 and `sm_start_o`=1 for exactly this cycle, then WAIT_BUSY.
- **WAIT_BUSY:**
  - Wait for `sm_ready_i`=0, then XFER.
  - Any `sm_dvalid_i` seen here is counted as in XFER.
- **XFER:**
  - Each `sm_dvalid_i` increments the byte counter (width `clog2(BLK_BYTES+1)`).
  - Write: `wr_take_o[winner]`=`sm_dvalid_i`.
  - Read: `rd_valid_o[winner]`=`sm_dvalid_i`.
  - When the counter reaches `BLK_BYTES`, go to DRAIN.
- **DRAIN:**
  - Wait for `sm_ready_i`=1.
  - Next cycle: `done_o[winner]`=1, `gnt_o`=0, `last`=winner, state IDLE.
  - `sm_dvalid_i` in DRAIN is ignored and not forwarded.
- **Datapath steering:**
  - `sm_dat_o`=`req_dat_i[winner]` combinationally while granted, else 0.
  - `rd_dat_o`=`sm_dat_i` combinationally.
- **Watchdog:**
  - Counts cycles in LAUNCH, WAIT_BUSY, XFER and DRAIN.
  - Cleared on every `sm_dvalid_i` and on every state change.
  - On reaching `TIMEOUT_CYCLES`: `err_o[winner]` pulses, `gnt_o` is dropped and `fault_o` is set. State goes to FAULT and stays there until `arst_i`.
- **Request sampling:**
  - `req_i` and `req_we_i` are sampled only in IDLE.
  - Deasserting `req_i` mid-grant does not abort the transfer.
- **Outputs:** `busy_o`=1 in every state except IDLE and FAULT.

## Timing
- **Reset values:**
  - `gnt_o`, `wr_take_o`, `rd_valid_o`, `done_o`, `err_o`, `fault_o`, `busy_o`, `sm_we_o`, `sm_start_o` are all 0.
  - `sm_dat_o`=0; state IDLE; counters 0.
- **Reset mid-transfer:** returns to IDLE immediately. The engine must be reset by the same `arst_i`.
- **Grant latency:** request seen in IDLE at cycle N (with `sm_ready_i`=1) gives `gnt_o` and `sm_start_o` at N+1.
- **Completion latency:** `sm_ready_i` rising in DRAIN at cycle M gives `done_o` at M+1. The earliest next arbitration is M+2.
- **Byte path:** `wr_take_o` and `rd_valid_o` are combinational from `sm_dvalid_i`, 0 cycles.
- **Simultaneous events:**
  - `sm_dvalid_i` on the cycle the watchdog would expire clears the watchdog.
  - The `BLK_BYTES`-th strobe and `sm_ready_i`=1 in the same cycle: go DRAIN, then `done_o` at +1.

## Test plan
- **Single read:** `req_i`=01, `req_we_i`=0; engine model drops ready 2 cycles after start and emits 512 strobes of 0x00..0xFF repeating.
  - `rd_valid_o[0]` pulses 512 times with matching `rd_dat_o`.
  - One `done_o`=01 pulse; `gnt_o` back to 0.
- **Contention:** `req_i`=11 held continuously.
  - Grants alternate 01, 10, 01, 10 over 4 transfers.
  - First grant goes to requester 0.
- **Write steering:** requester 1 writes an incrementing byte source.
  - `sm_we_o`=1 and `sm_dat_o` equals `req_dat_i[1]` on every strobe.
  - Exactly 512 `wr_take_o[1]` pulses.
- **Ready gating:** request with `sm_ready_i`=0 for 20 cycles.
  - No `gnt_o` or `sm_start_o` until ready is 1; grant follows 1 cycle later.
- **Timeout:** `TIMEOUT_CYCLES`=64; engine stops strobing after 100 bytes.
  - `err_o[winner]` pulses at the 64th idle cycle; `fault_o`=1 is held.
  - No further grants until `arst_i`.
- **Reset mid-XFER:** `arst_i` asserted after 300 bytes.
  - All outputs 0 immediately.
  - After release, a new request completes a full 512-byte transfer normally.
